uart_tx_param: RTL

//  Parametrised UART transmitter; next generation of the fixed 8N1 transmitter.

---
 rtl/uart_tx_param_if.sv | 33 +++
 rtl/uart_tx_param.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/uart_tx_param_if.sv
// uart_tx_param_if
//   Word handshake between a producer and the parametrised UART transmitter.
//   The producer presents a word on data with valid; the transmitter raises
//   ready while it can take a word. A transfer happens on the rising clock
//   edge where valid && ready.
// Signals
//   data   producer -> transmitter  DATA_BITS  word to send
//   valid  producer -> transmitter  1          data holds a word
//   ready  transmitter -> producer  1          transmitter is idle
// Modports
//   master  producer side (drives data/valid, observes ready)
//   slave   transmitter side (observes data/valid, drives ready)
interface uart_tx_param_if #(
  parameter int DATA_BITS = 8
) ();

  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 ready;

  modport master (
    output data,
    output valid,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    output ready
  );

endinterface

// File: rtl/uart_tx_param.sv
// uart_tx_param
//   Parametrised UART transmitter. Takes one word per valid/ready transfer and
//   serialises it LSB first onto TxD as: start bit (0), DATA_BITS data bits,
//   an optional parity bit, then STOP_BITS stop bits (1). Every bit is held
//   for CLKS_PER_BIT = CLK_FREQ / BAUD clock cycles. The line idles high.
// Parameters
//   CLK_FREQ   input clock frequency in Hz
//   BAUD       line rate in bit/s
//   DATA_BITS  data bits per frame (5..9)
//   PARITY     0 = none, 1 = odd, 2 = even
//   STOP_BITS  1 or 2
// Ports
//   clock  in   single clock domain
//   reset  in   synchronous, active-high; abandons any frame in progress
//   bus    slave side of uart_tx_param_if (data, valid in; ready out)
//   TxD    out  serial line, idle high
//   busy   out  frame in progress (inverse of ready)
//   done   out  one-cycle pulse in the last cycle of the last stop bit
module uart_tx_param #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD      = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic           clock,
  input  logic           reset,
  uart_tx_param_if.slave bus,
  output logic           TxD,
  output logic           busy,
  output logic           done
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  // A divisor of 1 would give $clog2 == 0; keep at least one counter bit.
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0] DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);
  localparam bit HAS_PARITY = (PARITY != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e               state_q, state_d;
  logic [BAUD_W-1:0]    baud_cnt_q, baud_cnt_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 parity_q, parity_d;

  logic ready;
  logic accept;
  logic bit_end;
  logic data_last;
  logic stop_last;

  assign accept    = bus.valid && ready;
  assign bit_end   = (baud_cnt_q == BAUD_LAST);
  assign data_last = (bit_cnt_q == DATA_LAST);
  assign stop_last = (bit_cnt_q == STOP_LAST);

  assign bus.ready = ready;
  assign busy      = ~ready;

  // State and datapath registers; reset returns everything to idle at once.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
    end
  end

  // Next-state logic: each non-idle state lasts whole bit times, and DATA and
  // STOP repeat until the bit counter reaches their last bit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_START;
      end
      S_START: begin
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        if (bit_end && data_last) state_d = HAS_PARITY ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        if (bit_end) state_d = S_STOP;
      end
      S_STOP: begin
        if (bit_end && stop_last) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: the word and its parity are captured only on the accept cycle,
  // so later activity on data/valid cannot disturb the frame. The baud counter
  // is held at 0 in idle, so the start bit begins on the cycle after accept.
  always_comb begin
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    case (state_q)
      S_IDLE: begin
        baud_cnt_d = '0;
        bit_cnt_d  = '0;
        if (accept) begin
          shift_d  = bus.data;
          parity_d = (PARITY == 1) ? ~(^bus.data) : ^bus.data;
        end
      end
      S_START, S_PARITY: begin
        baud_cnt_d = bit_end ? '0 : baud_cnt_q + BAUD_W'(1);
      end
      S_DATA: begin
        baud_cnt_d = bit_end ? '0 : baud_cnt_q + BAUD_W'(1);
        if (bit_end) begin
          shift_d   = shift_q >> 1;
          bit_cnt_d = data_last ? 4'd0 : bit_cnt_q + 4'd1;
        end
      end
      S_STOP: begin
        baud_cnt_d = bit_end ? '0 : baud_cnt_q + BAUD_W'(1);
        if (bit_end) begin
          bit_cnt_d = stop_last ? 4'd0 : bit_cnt_q + 4'd1;
        end
      end
      default: begin
        baud_cnt_d = '0;
        bit_cnt_d  = '0;
      end
    endcase
  end

  // Outputs are decoded from registered state only, so TxD cannot glitch on
  // input activity.
  always_comb begin
    TxD   = 1'b1;
    ready = 1'b0;
    done  = 1'b0;
    case (state_q)
      S_IDLE:   ready = 1'b1;
      S_START:  TxD   = 1'b0;
      S_DATA:   TxD   = shift_q[0];
      S_PARITY: TxD   = parity_q;
      S_STOP:   done  = bit_end && stop_last;
      default:  ready = 1'b0;
    endcase
  end

endmodule
